// File: rtl/m68k_bridge_pkg.sv
// Shared types and counter widths for the 68000 asynchronous-bus bridge.
package m68k_bridge_pkg;

    localparam int unsigned DLY_W = 4;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SLOT = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4,
        ST_BERR = 3'd5
    } bridge_state_t;

    function automatic logic in_access(input bridge_state_t s);
        return (s == ST_SLOT) || (s == ST_RD) || (s == ST_WR);
    endfunction

endpackage

// File: rtl/m68k_bus_bridge_p_sync.sv
// Multi-flop synchroniser for one asynchronous CPU strobe, with a selectable reset level.
module bus_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk28m,
    input  logic _reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk28m or negedge _reset) begin
        if (!_reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/m68k_bus_bridge_p.sv
// 68000 asynchronous bus to internal bus bridge: strobe sync, cck-gated access
// windows, /DTACK generation, bus-error timeout and abort on early /AS release.
module m68k_bus_bridge_p
    import m68k_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_DELAY    = 3,
    parameter int unsigned WR_DELAY    = 3,
    parameter bit          WAIT_CCK    = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk28m,
    input  logic              _reset,
    input  logic              _as,
    input  logic              r_w,
    input  logic              _uds,
    input  logic              _lds,
    input  logic [ADDR_W:1]   address,
    input  logic [15:0]       cpu_data_i,
    output logic [15:0]       cpu_data_o,
    output logic              cpu_data_oe,
    output logic              _dtack,
    output logic              _berr,
    output logic              rd,
    output logic              hwr,
    output logic              lwr,
    output logic [ADDR_W:1]   address_out,
    output logic [15:0]       data_out,
    input  logic [15:0]       data_in,
    input  logic              cck,
    input  logic              dbs,
    output logic              bls,
    output logic              busy
);

    logic as_s, rw_s, uds_s, lds_s;

    bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_as  (.clk28m(clk28m), ._reset(_reset), .d(_as),  .q(as_s));
    bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw  (.clk28m(clk28m), ._reset(_reset), .d(r_w),  .q(rw_s));
    bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_uds (.clk28m(clk28m), ._reset(_reset), .d(_uds), .q(uds_s));
    bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_lds (.clk28m(clk28m), ._reset(_reset), .d(_lds), .q(lds_s));

    bridge_state_t    state;
    logic [DLY_W-1:0] dly_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             rw_l, uds_l, lds_l;

    logic cck_ok, rd_last, wr_last, win_last, tmo_exp;

    assign cck_ok   = !WAIT_CCK || !cck;
    assign rd_last  = (dly_cnt == DLY_W'(RD_DELAY - 1));
    assign wr_last  = (dly_cnt == DLY_W'(WR_DELAY - 1));
    assign win_last = (state == ST_RD) ? rd_last : wr_last;
    assign tmo_exp  = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(1));

    assign bls  = dbs & in_access(state);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk28m or negedge _reset) begin
        if (!_reset) begin
            state       <= ST_IDLE;
            dly_cnt     <= '0;
            tmo_cnt     <= '0;
            rw_l        <= 1'b1;
            uds_l       <= 1'b1;
            lds_l       <= 1'b1;
            rd          <= 1'b0;
            hwr         <= 1'b0;
            lwr         <= 1'b0;
            _dtack      <= 1'b1;
            _berr       <= 1'b1;
            cpu_data_oe <= 1'b0;
            cpu_data_o  <= '0;
            address_out <= '0;
            data_out    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!as_s) begin
                        address_out <= address;
                        data_out    <= cpu_data_i;
                        rw_l        <= rw_s;
                        uds_l       <= uds_s;
                        lds_l       <= lds_s;
                        tmo_cnt     <= TMO_W'(TIMEOUT);
                        dly_cnt     <= '0;
                        state       <= ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                    end else if (tmo_exp) begin
                        state <= ST_BERR;
                        _berr <= 1'b0;
                    end else begin
                        if (TIMEOUT != 0) tmo_cnt <= tmo_cnt - TMO_W'(1);
                        if (cck_ok) begin
                            dly_cnt <= '0;
                            if (rw_l) begin
                                state <= ST_RD;
                                rd    <= 1'b1;
                            end else begin
                                state <= ST_WR;
                                hwr   <= ~uds_l;
                                lwr   <= ~lds_l;
                            end
                        end
                    end
                end
                ST_RD, ST_WR: begin
                    // Priority: abort, then completion, then timeout, then cck restart.
                    if (as_s) begin
                        state <= ST_IDLE;
                        rd    <= 1'b0;
                        hwr   <= 1'b0;
                        lwr   <= 1'b0;
                    end else if (cck_ok && win_last) begin
                        if (state == ST_RD) cpu_data_o <= data_in;
                        state <= ST_ACK;
                        rd    <= 1'b0;
                        hwr   <= 1'b0;
                        lwr   <= 1'b0;
                    end else if (tmo_exp) begin
                        state <= ST_BERR;
                        _berr <= 1'b0;
                        rd    <= 1'b0;
                        hwr   <= 1'b0;
                        lwr   <= 1'b0;
                    end else begin
                        if (TIMEOUT != 0) tmo_cnt <= tmo_cnt - TMO_W'(1);
                        if (cck_ok) begin
                            dly_cnt <= dly_cnt + DLY_W'(1);
                        end else begin
                            dly_cnt <= '0;
                            state   <= ST_SLOT;
                            rd      <= 1'b0;
                            hwr     <= 1'b0;
                            lwr     <= 1'b0;
                        end
                    end
                end
                ST_ACK: begin
                    if (as_s) begin
                        state       <= ST_IDLE;
                        _dtack      <= 1'b1;
                        cpu_data_oe <= 1'b0;
                    end else begin
                        _dtack      <= 1'b0;
                        cpu_data_oe <= rw_l;
                    end
                end
                ST_BERR: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                        _berr <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_bridge_p.sv
// Directed bench for m68k_bus_bridge_p: two instances (long and short timeout)
// checked every cycle against a transaction-level model plus literal checkpoints.
module tb_m68k_bus_bridge_p;

    localparam int S    = 2;
    localparam int D    = 3;
    localparam int HN   = 8192;

    logic        clk28m = 1'b0;
    logic        _reset = 1'b0;
    logic        _as = 1'b1, r_w = 1'b1, _uds = 1'b1, _lds = 1'b1;
    logic [23:1] address = '0;
    logic [15:0] cpu_data_i = '0, data_in = '0;
    logic        cck = 1'b0, dbs = 1'b0;

    logic [15:0] cpu_data_o_w [2];
    logic [15:0] data_out_w [2];
    logic [23:1] addr_out_w [2];
    logic        oe_w [2], dtack_w [2], berr_w [2], rd_w [2], hwr_w [2], lwr_w [2], bls_w [2], busy_w [2];

    always #5 clk28m = ~clk28m;

    m68k_bus_bridge_p #(.ADDR_W(23), .SYNC_STAGES(2), .RD_DELAY(3), .WR_DELAY(3), .WAIT_CCK(1), .TIMEOUT(255)) dut0 (
        .clk28m(clk28m), ._reset(_reset), ._as(_as), .r_w(r_w), ._uds(_uds), ._lds(_lds),
        .address(address), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o_w[0]), .cpu_data_oe(oe_w[0]),
        ._dtack(dtack_w[0]), ._berr(berr_w[0]), .rd(rd_w[0]), .hwr(hwr_w[0]), .lwr(lwr_w[0]),
        .address_out(addr_out_w[0]), .data_out(data_out_w[0]), .data_in(data_in), .cck(cck),
        .dbs(dbs), .bls(bls_w[0]), .busy(busy_w[0]));

    m68k_bus_bridge_p #(.ADDR_W(23), .SYNC_STAGES(2), .RD_DELAY(3), .WR_DELAY(3), .WAIT_CCK(1), .TIMEOUT(8)) dut1 (
        .clk28m(clk28m), ._reset(_reset), ._as(_as), .r_w(r_w), ._uds(_uds), ._lds(_lds),
        .address(address), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o_w[1]), .cpu_data_oe(oe_w[1]),
        ._dtack(dtack_w[1]), ._berr(berr_w[1]), .rd(rd_w[1]), .hwr(hwr_w[1]), .lwr(lwr_w[1]),
        .address_out(addr_out_w[1]), .data_out(data_out_w[1]), .data_in(data_in), .cck(cck),
        .dbs(dbs), .bls(bls_w[1]), .busy(busy_w[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: a transaction is idle (0), pending (1), acknowledged (2) or errored (3).
    int          edge_no;
    logic        as_h [HN], rw_h [HN], uds_h [HN], lds_h [HN];
    int          m_phase [2], m_run [2], m_age [2];
    bit          m_win [2];
    logic        m_rw [2], m_uds [2], m_lds [2];
    logic        e_rd [2], e_hwr [2], e_lwr [2], e_dtack [2], e_berr [2], e_oe [2];
    logic [15:0] e_rdata [2], e_wdata [2];
    logic [23:1] e_addr [2];
    logic        s_as, s_rw, s_uds, s_lds, slot_free;

    function automatic int tmo_lim(input int k);
        return (k == 0) ? 255 : 8;
    endfunction

    always @(posedge clk28m or negedge _reset) begin
        if (!_reset) begin
            edge_no = 0;
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_run[k] = 0; m_age[k] = 0; m_win[k] = 0;
                m_rw[k] = 1; m_uds[k] = 1; m_lds[k] = 1;
                e_rd[k] = 0; e_hwr[k] = 0; e_lwr[k] = 0; e_dtack[k] = 1; e_berr[k] = 1; e_oe[k] = 0;
                e_rdata[k] = '0; e_wdata[k] = '0; e_addr[k] = '0;
            end
        end else begin
            s_as  = (edge_no >= S) ? as_h[(edge_no - S) % HN]  : 1'b1;
            s_rw  = (edge_no >= S) ? rw_h[(edge_no - S) % HN]  : 1'b1;
            s_uds = (edge_no >= S) ? uds_h[(edge_no - S) % HN] : 1'b1;
            s_lds = (edge_no >= S) ? lds_h[(edge_no - S) % HN] : 1'b1;
            slot_free = !cck;
            for (int k = 0; k < 2; k++) begin
                case (m_phase[k])
                    0: if (!s_as) begin
                        e_addr[k] = address; e_wdata[k] = cpu_data_i;
                        m_rw[k] = s_rw; m_uds[k] = s_uds; m_lds[k] = s_lds;
                        m_phase[k] = 1; m_age[k] = 0; m_win[k] = 0; m_run[k] = 0;
                    end
                    1: begin
                        if (s_as) begin
                            m_phase[k] = 0;
                            e_rd[k] = 0; e_hwr[k] = 0; e_lwr[k] = 0;
                        end else begin
                            m_age[k]++;
                            if (m_win[k] && slot_free && m_run[k] == D - 1) begin
                                if (m_rw[k]) e_rdata[k] = data_in;
                                m_phase[k] = 2;
                                e_rd[k] = 0; e_hwr[k] = 0; e_lwr[k] = 0;
                            end else if (m_age[k] == tmo_lim(k)) begin
                                m_phase[k] = 3; e_berr[k] = 0;
                                e_rd[k] = 0; e_hwr[k] = 0; e_lwr[k] = 0;
                            end else if (slot_free) begin
                                if (m_win[k]) m_run[k]++;
                                else begin m_win[k] = 1; m_run[k] = 0; end
                                e_rd[k]  = m_rw[k];
                                e_hwr[k] = !m_rw[k] && !m_uds[k];
                                e_lwr[k] = !m_rw[k] && !m_lds[k];
                            end else begin
                                m_win[k] = 0; m_run[k] = 0;
                                e_rd[k] = 0; e_hwr[k] = 0; e_lwr[k] = 0;
                            end
                        end
                    end
                    2: if (s_as) begin
                        m_phase[k] = 0; e_dtack[k] = 1; e_oe[k] = 0;
                    end else begin
                        e_dtack[k] = 0; e_oe[k] = m_rw[k];
                    end
                    3: if (s_as) begin
                        m_phase[k] = 0; e_berr[k] = 1;
                    end
                    default: m_phase[k] = 0;
                endcase
            end
            as_h[edge_no % HN] = _as; rw_h[edge_no % HN] = r_w;
            uds_h[edge_no % HN] = _uds; lds_h[edge_no % HN] = _lds;
            edge_no++;
        end
    end

    always begin
        @(negedge clk28m);
        #1;
        if (_reset) begin
            for (int k = 0; k < 2; k++) begin
                chk("rd", k, rd_w[k], e_rd[k]);
                chk("hwr", k, hwr_w[k], e_hwr[k]);
                chk("lwr", k, lwr_w[k], e_lwr[k]);
                chk("dtack", k, dtack_w[k], e_dtack[k]);
                chk("berr", k, berr_w[k], e_berr[k]);
                chk("oe", k, oe_w[k], e_oe[k]);
                chk("cpu_data_o", k, cpu_data_o_w[k], e_rdata[k]);
                chk("data_out", k, data_out_w[k], e_wdata[k]);
                chk("address_out", k, addr_out_w[k], e_addr[k]);
                chk("busy", k, busy_w[k], m_phase[k] != 0);
                chk("bls", k, bls_w[k], dbs && m_phase[k] == 1);
                chk("dtack_berr_excl", k, !dtack_w[k] && !berr_w[k], 1'b0);
            end
        end
    end

    int t0, lat, cnt_h, cnt_l;
    bit found;

    task automatic start_cycle(input logic rw, input logic uds, input logic lds,
                               input logic [23:1] a, input logic [15:0] d);
        @(negedge clk28m);
        address = a; cpu_data_i = d; r_w = rw; _uds = uds; _lds = lds; _as = 1'b0;
        @(posedge clk28m); #1;
        t0 = edge_no;
    endtask

    task automatic wait_dtack(input string name);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk28m); #1;
            if (!dtack_w[0]) begin found = 1; lat = edge_no - t0; end
        end
        chk({name, "_dtack_seen"}, 0, found, 1'b1);
    endtask

    task automatic end_cycle(input string name);
        @(negedge clk28m);
        _as = 1'b1; _uds = 1'b1; _lds = 1'b1; r_w = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk28m); #1;
            if (!busy_w[0] && !busy_w[1]) found = 1;
        end
        chk({name, "_idle_seen"}, 0, found, 1'b1);
    endtask

    initial begin
        #12;
        chk("rst_dtack", 0, dtack_w[0], 1'b1);
        chk("rst_berr", 0, berr_w[0], 1'b1);
        chk("rst_rd", 0, rd_w[0], 1'b0);
        chk("rst_busy", 0, busy_w[0], 1'b0);
        chk("rst_addr", 0, addr_out_w[0], 23'h0);
        @(negedge clk28m); _reset = 1'b1;
        repeat (3) @(negedge clk28m);

        // Plain read with cck low.
        data_in = 16'hA55A;
        start_cycle(1'b1, 1'b0, 1'b0, 23'h012345, 16'h0000);
        wait_dtack("read");
        chk("read_latency", 0, lat, 7);
        chk("read_data", 0, cpu_data_o_w[0], 16'hA55A);
        chk("read_oe", 0, oe_w[0], 1'b1);
        chk("read_addr", 0, addr_out_w[0], 23'h012345);
        @(negedge clk28m); _as = 1'b1;
        @(posedge clk28m); #1; t0 = edge_no;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk28m); #1;
            if (dtack_w[0]) begin found = 1; lat = edge_no - t0; end
        end
        chk("read_release_seen", 0, found, 1'b1);
        chk("read_release_latency", 0, lat, 2);
        chk("read_release_oe", 0, oe_w[0], 1'b0);
        end_cycle("read");

        // Upper-byte write with data bus slowdown active.
        dbs = 1'b1;
        start_cycle(1'b0, 1'b0, 1'b1, 23'h7ABCDE, 16'h1234);
        cnt_h = 0; cnt_l = 0; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk28m); #1;
            cnt_h += int'(hwr_w[0]); cnt_l += int'(lwr_w[0]);
            if (!dtack_w[0]) begin found = 1; lat = edge_no - t0; end
        end
        chk("write_dtack_seen", 0, found, 1'b1);
        chk("write_latency", 0, lat, 7);
        chk("write_hwr_cycles", 0, cnt_h, 3);
        chk("write_lwr_cycles", 0, cnt_l, 0);
        chk("write_data_out", 0, data_out_w[0], 16'h1234);
        chk("write_oe", 0, oe_w[0], 1'b0);
        end_cycle("write");
        dbs = 1'b0;

        // Read with a one-cycle DMA slot in the middle of the window.
        data_in = 16'hC33C;
        start_cycle(1'b1, 1'b0, 1'b0, 23'h000100, 16'h0000);
        repeat (4) @(posedge clk28m);
        @(negedge clk28m); cck = 1'b1;
        chk("restart_rd_before", 0, rd_w[0], 1'b1);
        @(posedge clk28m); #1;
        chk("restart_rd_dropped", 0, rd_w[0], 1'b0);
        @(negedge clk28m); cck = 1'b0;
        wait_dtack("restart");
        chk("restart_latency", 0, lat, 10);
        chk("restart_data", 0, cpu_data_o_w[0], 16'hC33C);
        chk("restart_no_berr_short", 1, berr_w[1], 1'b1);
        end_cycle("restart");

        // Bus error on the short-timeout instance with cck stuck high.
        @(negedge clk28m); cck = 1'b1;
        start_cycle(1'b1, 1'b0, 1'b0, 23'h000200, 16'h0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy_w[1]) begin found = 1; t0 = edge_no; end
            else begin @(posedge clk28m); #1; end
        end
        chk("timeout_busy_seen", 1, found, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk28m); #1;
            if (!berr_w[1]) begin found = 1; lat = edge_no - t0; end
        end
        chk("timeout_berr_seen", 1, found, 1'b1);
        chk("timeout_latency", 1, lat, 8);
        chk("timeout_dtack", 1, dtack_w[1], 1'b1);
        chk("timeout_rd", 1, rd_w[1], 1'b0);
        chk("timeout_long_pending", 0, berr_w[0], 1'b1);
        end_cycle("timeout");
        chk("timeout_berr_released", 1, berr_w[1], 1'b1);
        @(negedge clk28m); cck = 1'b0;

        // Abort: /AS released so that as_s rises on the completion edge.
        data_in = 16'hDEAD;
        start_cycle(1'b1, 1'b0, 1'b0, 23'h000300, 16'h0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk28m); #1;
            if (rd_w[0]) found = 1;
        end
        chk("abort_rd_seen", 0, found, 1'b1);
        @(negedge clk28m); _as = 1'b1;
        @(posedge clk28m); #1; t0 = edge_no;
        @(posedge clk28m); #1;
        chk("abort_rd_still", 0, rd_w[0], 1'b1);
        @(posedge clk28m); #1;
        chk("abort_rd_dropped", 0, rd_w[0], 1'b0);
        cnt_h = 0;
        for (int i = 0; i < 10; i++) begin
            cnt_h += int'(!dtack_w[0]) + int'(!berr_w[0]) + int'(!dtack_w[1]) + int'(!berr_w[1]);
            @(posedge clk28m); #1;
        end
        chk("abort_no_ack", 0, cnt_h, 0);
        chk("abort_data_kept", 0, cpu_data_o_w[0], 16'hC33C);
        end_cycle("abort");

        // Asynchronous reset in the middle of a write.
        start_cycle(1'b0, 1'b0, 1'b0, 23'h000400, 16'hBEEF);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk28m); #1;
            if (hwr_w[0]) found = 1;
        end
        chk("rstwr_hwr_seen", 0, found, 1'b1);
        #1 _reset = 1'b0;
        #1;
        chk("rstwr_hwr", 0, hwr_w[0], 1'b0);
        chk("rstwr_lwr", 0, lwr_w[0], 1'b0);
        chk("rstwr_busy", 0, busy_w[0], 1'b0);
        chk("rstwr_data_out", 0, data_out_w[0], 16'h0000);
        _as = 1'b1; _uds = 1'b1; _lds = 1'b1; r_w = 1'b1;
        @(negedge clk28m); _reset = 1'b1;
        repeat (2) @(negedge clk28m);
        data_in = 16'h5AA5;
        start_cycle(1'b1, 1'b0, 1'b0, 23'h000500, 16'h0000);
        wait_dtack("after_reset");
        chk("after_reset_latency", 0, lat, 7);
        chk("after_reset_data", 0, cpu_data_o_w[0], 16'h5AA5);
        end_cycle("after_reset");

        repeat (3) @(negedge clk28m);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/m68k_bus_bridge_p.md
Name: m68k_bus_bridge_p

Overview:
- Parametrised next-generation 68000 asynchronous-bus to internal-bus bridge, clocked on clk28m.
- Synchronises the CPU strobes and waits for a free DMA slot (cck low).
- Runs programmable read/write access windows, returns /DTACK, and adds a bus-error timeout and clean abort handling.
- Sits between the CPU pins and the chipset/memory arbiter.

Parameters:
- ADDR_W, 23: CPU address width; the bus carries bits [ADDR_W:1].
- SYNC_STAGES, 2: synchroniser depth on _as, r_w, _uds, _lds. Legal range 2..3.
- RD_DELAY, 3: clk28m cycles of rd asserted with cck low before data_in is latched. Legal range 1..15.
- WR_DELAY, 3: clk28m cycles of hwr/lwr asserted with cck low before completion. Legal range 1..15.
- WAIT_CCK, 1: 1 = an access must start and run only while cck is low; 0 = cck is ignored.
- TIMEOUT, 255: cycles from access start to bus error. 0 disables the timeout.

Ports:
- clk28m, in, 1: sole clock.
- _reset, in, 1: asynchronous, active-low reset.
- _as, r_w, _uds, _lds, in, 1 each: raw CPU strobes, asynchronous to clk28m.
- address, in, ADDR_W: CPU address bits [ADDR_W:1].
- cpu_data_i, in, 16: CPU write data.
- cpu_data_o, out, 16: read data returned to the CPU.
- cpu_data_oe, out, 1: pad output enable for the CPU data bus.
- _dtack, out, 1: data acknowledge to the CPU.
- _berr, out, 1: bus error to the CPU.
- rd, hwr, lwr, out, 1 each: internal bus strobes.
- address_out, out, ADDR_W: latched address.
- data_out, out, 16: latched write data.
- data_in, in, 16: internal read data.
- cck, in, 1: colour clock; high = DMA slot.
- dbs, in, 1: data bus slowdown.
- bls, out, 1: blitter slowdown.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- Reset values:
  - rd, hwr, lwr, bls, busy, cpu_data_oe = 0.
  - _dtack, _berr = 1.
  - address_out, data_out, cpu_data_o = 0.
  - FSM = IDLE; all counters 0.
- Synchronisation: each strobe passes through SYNC_STAGES flops (reset value 1 for the active-low strobes, 1 for r_w). as_s is the last stage. address and cpu_data_i are sampled only in IDLE and are stable per the 68000 bus protocol.
- FSM states: IDLE, SLOT, RD, WR, ACK, BERR.
- IDLE:
  - On as_s == 0, latch address into address_out, cpu_data_i into data_out, and the synchronised r_w/_uds/_lds.
  - Load the timeout counter, then go to SLOT.
- SLOT:
  - If WAIT_CCK == 0, or cck == 0: go to RD if the latched r_w = 1, else go to WR.
  - Access counter is cleared.
- RD:
  - rd = 1 while (cck == 0 or WAIT_CCK == 0); the counter increments each such cycle.
  - If cck goes high, rd drops, the counter clears, and the FSM returns to SLOT (the window restarts).
  - On the cycle where counter == RD_DELAY-1, capture data_in into cpu_data_o and go to ACK.
- WR:
  - hwr = ~latched _uds and lwr = ~latched _lds, both gated by the same cck rule.
  - Counter and restart behaviour match RD, using WR_DELAY; go to ACK on completion.
- ACK:
  - _dtack = 0; cpu_data_oe = latched r_w.
  - Hold until as_s == 1, then go to IDLE. _dtack and cpu_data_oe return high/low on the same edge.
- Timeout:
  - While in SLOT/RD/WR with TIMEOUT != 0, the counter decrements each cycle.
  - On reaching 0 before ACK: go to BERR. _berr = 0, all strobes drop, and no data is driven.
  - Hold BERR until as_s == 1, then go to IDLE.
- Abort: as_s == 1 while in SLOT/RD/WR returns the FSM to IDLE on the next edge. Strobes drop that edge; no _dtack or _berr is issued.
- Simultaneous events:
  - Timeout expiry and counter completion on the same cycle: completion wins.
  - Abort and completion on the same cycle: abort wins.
- Exclusivity: _dtack and _berr are never low together. rd, hwr and lwr are never asserted outside RD/WR.
- bls = dbs & (state in SLOT, RD, WR).
- busy = state != IDLE.
- Latency: with cck held low and WAIT_CCK = 1, _dtack falls SYNC_STAGES + RD_DELAY + 2 edges after the first clk28m edge that samples _as low. Writes follow the same formula with WR_DELAY.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously).

Decomposition:
- Package m68k_bridge_pkg: FSM state encoding (3 bits) and the counter widths (delay counter 4 bits, timeout counter 8 bits).
- One sub-module, bus_sync: SYNC_STAGES-deep synchroniser with a per-instance reset value, instantiated once per strobe.

Test Plan:
- Read, SYNC=2, RD_DELAY=3, cck=0, data_in=16'hA55A: _dtack falls 7 edges after _as is sampled low; cpu_data_o=16'hA55A, cpu_data_oe=1; _dtack returns high 1 edge after as_s goes high.
- Byte write, _uds=0, _lds=1, cpu_data_i=16'h1234, WR_DELAY=3: hwr=1 for 3 cycles, lwr stays 0, data_out=16'h1234, then _dtack falls.
- Read with cck pulsed high at window cycle 2: rd drops, counter restarts, and _dtack is delayed by the restart length; data is captured only after 3 contiguous cck-low cycles.
- TIMEOUT=8 with cck held high: _berr falls 8 cycles after leaving IDLE and _dtack stays 1; _berr rises after _as goes high.
- _as released during RD: rd drops on the next edge, and neither _dtack nor _berr ever asserts.
- _reset asserted during WR: hwr and lwr drop immediately and FSM=IDLE; after release, the next read completes normally.
